// File: rtl/uart_tx_frame_if.sv
// Client-side handshake and serial line bundle for uart_tx_frame.
// The client uses the master view; the transmitter uses the slave view.
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              tx;
  logic              busy;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  tx,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output tx,
    output busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_W data bits LSB first, optional
// parity, 1 or 2 stop bits, each bit held for CLKS_PER_BIT clocks.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | line high, waiting for a word
// S_START | start bit (line low)
// S_DATA  | data bits, LSB first, taken from shift_q[0]
// S_PAR   | parity bit (only when PARITY != 0)
// S_STOP  | stop bit(s), line high; last cycle may accept the next word
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave bus
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_frame: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_q;
  logic                tx_q;
  logic                busy_q;

  logic baud_last;
  logic stop_done;
  logic xfer;
  logic par_in;

  assign baud_last = (baud_q == BAUD_LAST);
  assign stop_done = (state_q == S_STOP) && baud_last && (bit_q == STOP_LAST);

  // Ready is combinational so the final stop cycle can accept the next word
  // and the following start bit leaves no idle gap on the line.
  assign bus.in_ready = rst && ((state_q == S_IDLE) || stop_done);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign par_in       = (PARITY == 2) ? ~(^bus.in_data) : (^bus.in_data);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else if (xfer) begin
      state_q <= S_START;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= bus.in_data;
      par_q   <= par_in;
      tx_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PAR;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_PAR: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q   <= '0;
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;

endmodule
